alu_dispatch: RTL

Issue controller for the two-stage `alu`. It accepts operation requests over a valid/ready handshake and drives the ALU inputs. It drives `CARRY_SEL` one cycle after the operands, as the ALU's timing requires, and captures each result and its flags when they appear two cycles later. Results queue in a response FIFO with backpressure, and an architectural flag register is kept for the control unit.

---
 rtl/alu_dispatch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// Issue controller for the two-stage alu: request handshake, carry select,
// result capture into an in-order response FIFO and architectural flags.
module alu_dispatch #(
  parameter int RSP_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [7:0] REQ_LHS,
  input  logic [7:0] REQ_RHS,
  input  logic [3:0] REQ_LOGIC_OP,
  input  logic [2:0] REQ_SHIFT_OP,
  input  logic [1:0] REQ_CARRY_MODE,
  input  logic       REQ_UPDATE_FLAGS,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_RESULT,
  output logic [4:0] RSP_FLAGS,
  output logic [4:0] FLAGS,
  output logic [7:0] ALU_LHS,
  output logic [7:0] ALU_RHS,
  output logic [3:0] ALU_LOGIC_OP,
  output logic [2:0] ALU_SHIFT_OP,
  output logic [2:0] ALU_CARRY_SEL,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_OVERFLOW,
  input  logic       ALU_NEGATIVE,
  input  logic       ALU_ZERO,
  input  logic       ALU_ARITH_CARRY,
  input  logic       ALU_LOGIC_CARRY
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam logic [AW+1:0] DEPTH_U = (AW+2)'(RSP_DEPTH);

  logic          s1_valid_q, s1_valid_d;
  logic          s1_upd_q, s1_upd_d;
  logic          s1_b2b_q, s1_b2b_d;
  logic [1:0]    s1_mode_q, s1_mode_d;
  logic          s2_valid_q, s2_valid_d;
  logic          s2_upd_q, s2_upd_d;
  logic          c_last_q, c_last_d;
  logic [4:0]    flags_q, flags_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [12:0]   mem_q [RSP_DEPTH];
  logic [12:0]   mem_d [RSP_DEPTH];

  logic [AW+1:0] used;
  logic          accept;
  logic          push;
  logic          pop;
  logic [4:0]    alu_flags;

  always_comb begin
    used = (AW+2)'(s1_valid_q) + (AW+2)'(s2_valid_q)
         + {1'b0, cnt_q};
    // Held low during reset so every output reads 0 while RST is high.
    REQ_READY = !RST && (used < DEPTH_U);
    accept    = REQ_VALID && REQ_READY;

    ALU_LHS      = accept ? REQ_LHS      : '0;
    ALU_RHS      = accept ? REQ_RHS      : '0;
    ALU_LOGIC_OP = accept ? REQ_LOGIC_OP : '0;
    ALU_SHIFT_OP = accept ? REQ_SHIFT_OP : '0;

    ALU_CARRY_SEL = 3'b000;
    if (s1_valid_q) begin
      unique case (s1_mode_q)
        2'b01:   ALU_CARRY_SEL = 3'b001;
        2'b10:   ALU_CARRY_SEL = s1_b2b_q ? 3'b010
                                          : {2'b00, c_last_q};
        default: ALU_CARRY_SEL = 3'b000;
      endcase
    end

    alu_flags = {ALU_OVERFLOW, ALU_NEGATIVE, ALU_ZERO,
                 ALU_ARITH_CARRY, ALU_LOGIC_CARRY};

    push      = s2_valid_q;
    RSP_VALID = (cnt_q != '0);
    pop       = RSP_VALID && RSP_READY;

    RSP_RESULT = RSP_VALID ? mem_q[rd_ptr_q][12:5] : '0;
    RSP_FLAGS  = RSP_VALID ? mem_q[rd_ptr_q][4:0]  : '0;
    FLAGS      = flags_q;
  end

  always_comb begin
    s1_valid_d = accept;
    s1_upd_d   = accept && REQ_UPDATE_FLAGS;
    s1_mode_d  = accept ? REQ_CARRY_MODE : 2'b00;
    // Predecessor accepted last cycle is sitting in S1 right now.
    s1_b2b_d   = accept && s1_valid_q;
    s2_valid_d = s1_valid_q;
    s2_upd_d   = s1_upd_q;

    c_last_d = c_last_q;
    flags_d  = flags_q;
    if (push) begin
      c_last_d = ALU_ARITH_CARRY;
      if (s2_upd_q) flags_d = alu_flags;
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {ALU_RESULT, alu_flags};

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_upd_q   <= 1'b0;
      s1_b2b_q   <= 1'b0;
      s1_mode_q  <= 2'b00;
      s2_valid_q <= 1'b0;
      s2_upd_q   <= 1'b0;
      c_last_q   <= 1'b0;
      flags_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_upd_q   <= s1_upd_d;
      s1_b2b_q   <= s1_b2b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_upd_q   <= s2_upd_d;
      c_last_q   <= c_last_d;
      flags_q    <= flags_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule
